// File: rtl/tcs_pkg.sv
// tcs_pkg: shared mode constants and default geometry
// for the pipelined two's-complement adder/subtractor.
package tcs_pkg;

    localparam logic TCS_ADD = 1'b0;
    localparam logic TCS_SUB = 1'b1;

    localparam int TCS_WIDTH = 8;
    localparam int TCS_CHUNK = 4;

endpackage

// File: rtl/tcs_chunk.sv
// tcs_chunk: WIDTH-bit ripple adder slice, also exporting
// the carry into its top bit for signed overflow detection.
module tcs_chunk #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic [WIDTH:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[WIDTH];
    assign cmsb = c[WIDTH-1];

endmodule

// File: rtl/tcs_addsub_pipe.sv
// tcs_addsub_pipe: carry-chunked pipelined add/sub, CHUNK bits per stage.
// Define TCS_SAT_EN to saturate the result on signed overflow.
module tcs_addsub_pipe
    import tcs_pkg::*;
#(
    parameter int WIDTH = TCS_WIDTH,
    parameter int CHUNK = TCS_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    logic             adv;

    logic [WIDTH-1:0] ra [STAGES];
    logic [WIDTH-1:0] rb [STAGES];
    logic [WIDTH-1:0] rs [STAGES];
    logic             rv [STAGES];
    logic             rc [STAGES];
    logic             rm [STAGES];

    logic [WIDTH-1:0] xa [STAGES];
    logic [WIDTH-1:0] xb [STAGES];
    logic [WIDTH-1:0] xs [STAGES];
    logic             xv [STAGES];
    logic             xc [STAGES];

    logic [CHUNK-1:0] cs [STAGES];
    logic             co [STAGES];
    logic             cm [STAGES];
    logic [WIDTH-1:0] ns [STAGES];

    logic             unused_regs;

    assign adv       = !rv[LAST] || out_ready;
    assign in_ready  = adv;
    assign out_valid = rv[LAST];

    // b is inverted up front and the +1 rides in as chunk 0's carry
    always_comb begin
        xa[0] = a;
        xb[0] = b ^ {WIDTH{sub == TCS_SUB}};
        xs[0] = '0;
        xv[0] = in_valid;
        xc[0] = (sub != TCS_ADD);
        for (int k = 1; k < STAGES; k++) begin
            xa[k] = ra[k-1];
            xb[k] = rb[k-1];
            xs[k] = rs[k-1];
            xv[k] = rv[k-1];
            xc[k] = rc[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        tcs_chunk #(
            .WIDTH(CHUNK)
        ) u_chunk (
            .a   (xa[k][k*CHUNK +: CHUNK]),
            .b   (xb[k][k*CHUNK +: CHUNK]),
            .cin (xc[k]),
            .s   (cs[k]),
            .cout(co[k]),
            .cmsb(cm[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            ns[k] = xs[k];
            ns[k][k*CHUNK +: CHUNK] = cs[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                rv[k] <= 1'b0;
                ra[k] <= '0;
                rb[k] <= '0;
                rs[k] <= '0;
                rc[k] <= 1'b0;
                rm[k] <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                rv[k] <= xv[k];
                ra[k] <= xa[k];
                rb[k] <= xb[k];
                rs[k] <= ns[k];
                rc[k] <= co[k];
                rm[k] <= cm[k];
            end
        end
    end

    assign carry    = rc[LAST];
    assign overflow = rm[LAST] ^ rc[LAST];

`ifdef TCS_SAT_EN
    always_comb begin
        sum = rs[LAST];
        if (overflow) begin
            sum = ra[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign sum = rs[LAST];
`endif

    // operand bits fully consumed by the last stage, MSB-carry of inner stages
    always_comb begin
        unused_regs = ^{ra[LAST], rb[LAST]};
        for (int k = 0; k < LAST; k++) begin
            unused_regs = unused_regs ^ rm[k];
        end
    end

endmodule

// File: tb/tb_tcs_addsub_pipe.sv
// tb_tcs_addsub_pipe: randomized and directed checks of the add/sub
// pipeline against an integer-arithmetic reference model.
module tb_tcs_addsub_pipe;

    logic       clk;
    logic       rst_n;

    logic       in_valid, in_ready, sub, out_valid, out_ready;
    logic       carry, overflow;
    logic [7:0] a, b, sum;

    logic       in_valid6, in_ready6, sub6, out_valid6, out_ready6;
    logic       carry6, overflow6;
    logic [5:0] a6, b6, sum6;

    int checks = 0;
    int errors = 0;

    tcs_addsub_pipe #(.WIDTH(8), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry(carry), .overflow(overflow)
    );

    tcs_addsub_pipe #(.WIDTH(6), .CHUNK(2)) dut6 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid6), .in_ready(in_ready6),
        .a(a6), .b(b6), .sub(sub6),
        .out_valid(out_valid6), .out_ready(out_ready6),
        .sum(sum6), .carry(carry6), .overflow(overflow6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic void ref_model(input int w, input int ua, input int ub,
                                      input bit s, output int rs,
                                      output bit rc, output bit ro);
        int m, lim, raw, sa, sb, sr;
        m   = (1 << w) - 1;
        lim = 1 << (w - 1);
        raw = s ? ua + ((~ub) & m) + 1 : ua + ub;
        rc  = ((raw >> w) & 1) != 0;
        sa  = (ua >= lim) ? ua - (1 << w) : ua;
        sb  = (ub >= lim) ? ub - (1 << w) : ub;
        sr  = s ? sa - sb : sa + sb;
        ro  = (sr > lim - 1) || (sr < -lim);
        rs  = raw & m;
`ifdef TCS_SAT_EN
        if (ro) rs = (sa < 0) ? lim : lim - 1;
`endif
    endfunction

    task automatic test_reset();
        #3;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_out_valid got=%b required=0", out_valid);
        end
        checks++;
        if ({overflow, carry, sum} !== 10'h0) begin
            errors++;
            $display("FAIL rst_outputs got=%h required=000",
                     {overflow, carry, sum});
        end
        checks++;
        if (out_valid6 !== 1'b0) begin
            errors++;
            $display("FAIL rst_out_valid6 got=%b required=0", out_valid6);
        end
        #3 rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_in_ready got=%b required=1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [7:0] ta [4] = '{8'h7F, 8'h00, 8'h80, 8'hFF};
        logic [7:0] tb [4] = '{8'h01, 8'h01, 8'h01, 8'h01};
        logic       ts [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
`ifdef TCS_SAT_EN
        logic [7:0] es [4] = '{8'h7F, 8'hFF, 8'h80, 8'h00};
`else
        logic [7:0] es [4] = '{8'h80, 8'hFF, 8'h7F, 8'h00};
`endif
        logic       ec [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic       eo [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = ta[i]; b = tb[i]; sub = ts[i]; in_valid = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL dir%0d_in_ready got=%b required=1", i, in_ready);
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 10) begin
                @(posedge clk);
                #1;
                lat++;
            end
            checks++;
            if (lat !== 2) begin
                errors++;
                $display("FAIL dir%0d_latency got=%0d required=2", i, lat);
            end
            checks++;
            if (sum !== es[i]) begin
                errors++;
                $display("FAIL dir%0d_sum got=%h required=%h", i, sum, es[i]);
            end
            checks++;
            if (carry !== ec[i]) begin
                errors++;
                $display("FAIL dir%0d_carry got=%b required=%b", i, carry, ec[i]);
            end
            checks++;
            if (overflow !== eo[i]) begin
                errors++;
                $display("FAIL dir%0d_ovf got=%b required=%b", i, overflow, eo[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_stall();
        logic [7:0] ta [3];
        logic [7:0] tb [3];
        logic       ts [3];
        logic [9:0] e  [3];
        int rs, got;
        bit rc, ro, fi, fo, seen;
        for (int i = 0; i < 3; i++) begin
            ta[i] = 8'($urandom);
            tb[i] = 8'($urandom);
            ts[i] = 1'($urandom);
            ref_model(8, ta[i], tb[i], ts[i], rs, rc, ro);
            e[i] = {ro, rc, rs[7:0]};
        end
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a = ta[i]; b = tb[i]; sub = ts[i]; in_valid = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stall_fill%0d got=%b required=1", i, in_ready);
            end
            @(posedge clk);
            #1;
        end
        a = ta[2]; b = tb[2]; sub = ts[2];
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hs%0d got=%b%b required=01",
                         i, in_ready, out_valid);
            end
            checks++;
            if ({overflow, carry, sum} !== e[0]) begin
                errors++;
                $display("FAIL stall_hold%0d got=%h required=%h",
                         i, {overflow, carry, sum}, e[0]);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
            #1;
            fi = in_valid && in_ready;
            fo = out_valid && out_ready;
            if (fo) begin
                checks++;
                if ({overflow, carry, sum} !== e[got]) begin
                    errors++;
                    $display("FAIL stall_out%0d got=%h required=%h",
                             got, {overflow, carry, sum}, e[got]);
                end
                got++;
            end
            @(posedge clk);
            #1;
            if (fi) in_valid = 1'b0;
        end
        checks++;
        if (got !== 3) begin
            errors++;
            $display("FAIL stall_count got=%0d required=3", got);
        end
        seen = 1'b0;
        repeat (4) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL stall_dup got=1 required=0");
        end
    endtask

    task automatic test_reset_inflight();
        int lat;
        bit seen;
        out_ready = 1'b1;
        a = 8'h12; b = 8'h34; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        a = 8'h56; b = 8'h01; sub = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rif_setup got=%b required=1", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rif_async got=%b required=0", out_valid);
        end
        checks++;
        if ({overflow, carry, sum} !== 10'h0) begin
            errors++;
            $display("FAIL rif_clear got=%h required=000",
                     {overflow, carry, sum});
        end
        #3 rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rif_ghost got=1 required=0");
        end
        a = 8'h3C; b = 8'h0F; sub = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL rif_latency got=%0d required=2", lat);
        end
        checks++;
        if ({overflow, carry, sum} !== {1'b0, 1'b1, 8'h2D}) begin
            errors++;
            $display("FAIL rif_result got=%h required=%h",
                     {overflow, carry, sum}, {1'b0, 1'b1, 8'h2D});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back(input int n, input bit sweep);
        logic [9:0] q [$];
        logic [9:0] e, held;
        int sent, got, cyc, rs;
        bit rc, ro, fi, fo, hold_v;
        sent = 0; got = 0; cyc = 0; hold_v = 1'b0; held = '0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (got < n && cyc < n * 8 + 100) begin
            if (!in_valid && sent < n && (sweep || $urandom_range(0, 3) != 0)) begin
                if (sweep) begin
                    a = sent[11:4]; sub = sent[3]; b = 8'($urandom);
                end else begin
                    a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
                end
                in_valid = 1'b1;
            end
            if (!sweep) out_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++;
                $display("FAIL b2b_in_ready cyc=%0d got=%b required=%b",
                         cyc, in_ready, !out_valid || out_ready);
            end
            if (hold_v) begin
                checks++;
                if (out_valid !== 1'b1 || {overflow, carry, sum} !== held) begin
                    errors++;
                    $display("FAIL b2b_hold cyc=%0d got=%b/%h required=1/%h",
                             cyc, out_valid, {overflow, carry, sum}, held);
                end
            end
            hold_v = out_valid && !out_ready;
            held = {overflow, carry, sum};
            fi = in_valid && in_ready;
            fo = out_valid && out_ready;
            if (fo) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra got=%h required=none",
                             {overflow, carry, sum});
                end else begin
                    e = q.pop_front();
                    if ({overflow, carry, sum} !== e) begin
                        errors++;
                        $display("FAIL b2b_result n=%0d got=%h required=%h",
                                 got, {overflow, carry, sum}, e);
                    end
                end
                got++;
            end
            if (fi) begin
                ref_model(8, a, b, sub, rs, rc, ro);
                q.push_back({ro, rc, rs[7:0]});
                sent++;
            end
            @(posedge clk);
            #1;
            if (fi) in_valid = 1'b0;
            cyc++;
        end
        checks++;
        if (got !== n || q.size() !== 0) begin
            errors++;
            $display("FAIL b2b_count got=%0d/%0d required=%0d/0", got, q.size(), n);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_sweep6();
        logic [7:0] q [$];
        logic [7:0] e;
        int sent, got, cyc, rs;
        bit rc, ro, fi, fo;
        sent = 0; got = 0; cyc = 0;
        out_ready6 = 1'b1;
        in_valid6 = 1'b0;
        while (got < 8192 && cyc < 9000) begin
            if (!in_valid6 && sent < 8192) begin
                a6 = sent[12:7]; b6 = sent[6:1]; sub6 = sent[0];
                in_valid6 = 1'b1;
            end
            #1;
            fi = in_valid6 && in_ready6;
            fo = out_valid6 && out_ready6;
            if (fo) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL sw6_extra got=%h required=none",
                             {overflow6, carry6, sum6});
                end else begin
                    e = q.pop_front();
                    if ({overflow6, carry6, sum6} !== e) begin
                        errors++;
                        $display("FAIL sw6_result n=%0d got=%h required=%h",
                                 got, {overflow6, carry6, sum6}, e);
                    end
                end
                got++;
            end
            if (fi) begin
                ref_model(6, a6, b6, sub6, rs, rc, ro);
                q.push_back({ro, rc, rs[5:0]});
                sent++;
            end
            @(posedge clk);
            #1;
            if (fi) in_valid6 = 1'b0;
            cyc++;
        end
        checks++;
        if (got !== 8192 || cyc > 8200) begin
            errors++;
            $display("FAIL sw6_count got=%0d cyc=%0d required=8192 within 8200",
                     got, cyc);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
        in_valid6 = 1'b0; a6 = '0; b6 = '0; sub6 = 1'b0; out_ready6 = 1'b1;
        test_reset();
        test_directed();
        test_stall();
        test_reset_inflight();
        test_back_to_back(3000, 1'b0);
        test_back_to_back(4096, 1'b1);
        test_sweep6();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
